sfr_shadow_reg: RTL and testbench

Parametrised, double-buffered special-function register for the 8051 SoC SFR space. It generalises the single-byte control registers to any width and adds per-bit set/clear/toggle operations. Writes land in a shadow copy that transfers to the active copy either immediately or on a synchronisation strobe, such as a PWM or timer period boundary. An optional key-sequence write protection is also provided. It sits between the SFR decode/operation bus and the peripheral that consumes `o_active`.

---
 rtl/sfr_pkg.sv | 33 +++
 rtl/sfr_shadow_reg_if.sv | 28 ++
 rtl/sfr_shadow_reg_key_fsm.sv | 73 +++++++
 rtl/sfr_shadow_reg.sv | 111 +++++++++++
 tb/tb_sfr_shadow_reg.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sfr_pkg.sv
// sfr_pkg: op masks, key bytes and key-FSM encoding for sfr_shadow_reg.
// SFR_OP_LEN sets the op bus width (default 5).
`ifndef SFR_OP_LEN
`define SFR_OP_LEN 5
`endif

package sfr_pkg;

    localparam int OPW = `SFR_OP_LEN;

    localparam logic [OPW-1:0] OP_SFR_WR  = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_SFR_CLR = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_SFR_SET = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_SFR_TGL = OPW'(5'b01000);
    localparam logic [OPW-1:0] OP_SFR_KEY = OPW'(5'b10000);

    localparam logic [7:0] SFR_KEY1 = 8'hAA;
    localparam logic [7:0] SFR_KEY2 = 8'h55;

    typedef enum logic [1:0] {
        KEY_LOCKED = 2'd0,
        KEY_KEY1   = 2'd1,
        KEY_OPEN   = 2'd2
    } key_state_e;

    function automatic logic op_has(
        input logic [OPW-1:0] op,
        input logic [OPW-1:0] mask
    );
        return |(op & mask);
    endfunction

endpackage

// File: rtl/sfr_shadow_reg_if.sv
// sfr_if: SFR operation bus plus active/shadow readback.
// i_bit carries one extra bit so out-of-range indices are representable.
interface sfr_if #(
    parameter int WIDTH = 8
);
    import sfr_pkg::*;

    logic [OPW-1:0]         i_op;
    logic [WIDTH-1:0]       i_data;
    logic [$clog2(WIDTH):0] i_bit;
    logic                   i_sync_mode;
    logic                   i_sync;
    logic [WIDTH-1:0]       o_active;
    logic [WIDTH-1:0]       o_shadow;
    logic                   o_pending;
    logic                   o_locked;

    modport master (
        output i_op, i_data, i_bit, i_sync_mode, i_sync,
        input  o_active, o_shadow, o_pending, o_locked
    );

    modport slave (
        input  i_op, i_data, i_bit, i_sync_mode, i_sync,
        output o_active, o_shadow, o_pending, o_locked
    );

endinterface

// File: rtl/sfr_shadow_reg_key_fsm.sv
// sfr_key_fsm: AA/55 unlock sequence with a bounded window; one op per unlock.
// o_relock pulses when the open window is consumed by a modifying op.
module sfr_key_fsm
    import sfr_pkg::*;
#(
    parameter int UNLOCK_WINDOW = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key,
    input  logic [7:0] i_key_byte,
    input  logic       i_mod,
    output logic       o_locked,
    output logic       o_relock
);

    localparam int CW = $clog2(UNLOCK_WINDOW + 1);

    key_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= KEY_LOCKED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        o_relock = 1'b0;
        unique case (state_q)
            KEY_LOCKED: begin
                if (i_key && i_key_byte == SFR_KEY1) begin
                    state_d = KEY_KEY1;
                    cnt_d   = CW'(UNLOCK_WINDOW);
                end
            end
            KEY_KEY1: begin
                if (i_key) begin
                    if (i_key_byte == SFR_KEY2) begin
                        state_d = KEY_OPEN;
                        cnt_d   = CW'(UNLOCK_WINDOW);
                    end else begin
                        state_d = KEY_LOCKED;
                    end
                end else if (cnt_q == '0) begin
                    state_d = KEY_LOCKED;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            KEY_OPEN: begin
                if (i_mod) begin
                    o_relock = 1'b1;
                    state_d  = KEY_LOCKED;
                end else if (cnt_q == '0) begin
                    state_d = KEY_LOCKED;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = KEY_LOCKED;
        endcase
    end

    assign o_locked = (state_q != KEY_OPEN);

endmodule

// File: rtl/sfr_shadow_reg.sv
// sfr_shadow_reg: double-buffered SFR with bit set/clear/toggle and sync transfer.
// Define SFR_LOCK_EN to gate modifying ops behind the AA/55 key sequence.
module sfr_shadow_reg
    import sfr_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] RESET_VAL     = WIDTH'(8'h0F),
    parameter int               UNLOCK_WINDOW = 4
) (
    input  logic  i_clk,
    input  logic  i_rst,
    sfr_if.slave  bus
);

    localparam int BI = $clog2(WIDTH);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] nxt;
    logic [BI-1:0]    idx;
    logic             wr, clr, set, tgl, mod_any;
    logic             bit_ok, hit, accept, apply, locked;

    assign wr      = op_has(bus.i_op, OP_SFR_WR);
    assign clr     = op_has(bus.i_op, OP_SFR_CLR);
    assign set     = op_has(bus.i_op, OP_SFR_SET);
    assign tgl     = op_has(bus.i_op, OP_SFR_TGL);
    assign mod_any = wr | clr | set | tgl;
    assign idx     = bus.i_bit[BI-1:0];
    assign bit_ok  = (32'(bus.i_bit) < WIDTH);

`ifdef SFR_LOCK_EN
    sfr_key_fsm #(
        .UNLOCK_WINDOW (UNLOCK_WINDOW)
    ) u_key (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_key      (op_has(bus.i_op, OP_SFR_KEY)),
        .i_key_byte (bus.i_data[7:0]),
        .i_mod      (mod_any),
        .o_locked   (locked),
        .o_relock   (accept)
    );
`else
    assign locked = 1'b0;
    assign accept = mod_any;
`endif

    // Only the highest-priority requested op is considered
    always_comb begin
        nxt = shadow_q;
        hit = 1'b0;
        priority case (1'b1)
            wr: begin
                nxt = bus.i_data;
                hit = 1'b1;
            end
            clr: if (bit_ok) begin
                nxt[idx] = 1'b0;
                hit      = 1'b1;
            end
            set: if (bit_ok) begin
                nxt[idx] = 1'b1;
                hit      = 1'b1;
            end
            tgl: if (bit_ok) begin
                nxt[idx] = ~shadow_q[idx];
                hit      = 1'b1;
            end
            default: ;
        endcase
    end

    assign apply = accept & hit;

    always_comb begin
        shadow_d  = apply ? nxt : shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (!bus.i_sync_mode) begin
            // Also flushes a pending shadow when the mode drops
            active_d  = shadow_d;
            pending_d = 1'b0;
        end else begin
            if (bus.i_sync && pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
            if (apply) pending_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow_q  <= RESET_VAL;
            active_q  <= RESET_VAL;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign bus.o_active  = active_q;
    assign bus.o_shadow  = shadow_q;
    assign bus.o_pending = pending_q;
    assign bus.o_locked  = locked;

endmodule

// File: tb/tb_sfr_shadow_reg.sv
// tb_sfr_shadow_reg: directed scenarios plus random ops against a reference model.
// Compile with or without SFR_LOCK_EN to match the DUT build.
module tb_sfr_shadow_reg;
    import sfr_pkg::*;

    localparam int W   = 8;
    localparam int WIN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;

    sfr_if #(.WIDTH(W)) bus ();

    sfr_shadow_reg #(
        .WIDTH         (W),
        .RESET_VAL     (8'h0F),
        .UNLOCK_WINDOW (WIN)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: register copies plus an unlock phase and the cycle
    // number of the last accepted key byte.
    logic [7:0] m_sh, m_ac;
    bit         m_pend;
    int         m_phase, m_last, m_cyc;

    task automatic model_reset();
        m_sh = 8'h0F; m_ac = 8'h0F; m_pend = 0;
        m_phase = 0; m_last = 0; m_cyc = 0;
    endtask

    function automatic bit m_locked();
`ifdef SFR_LOCK_EN
        return !(m_phase == 2 && (m_cyc - m_last) <= WIN + 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step(input logic [4:0] op, input logic [7:0] d,
                              input int b, input bit mode, input bit sync);
        bit         acc, chg;
        logic [7:0] nv;
`ifdef SFR_LOCK_EN
        if (m_phase != 0 && (m_cyc - m_last) > WIN + 1) m_phase = 0;
`endif
        acc = !m_locked() && (op[3:0] != 4'b0);
        nv  = m_sh;
        chg = 0;
        if (acc) begin
            if (op[0]) begin nv = d; chg = 1; end
            else if (b < W) begin
                chg = 1;
                if (op[1])      nv = m_sh & ~(8'h01 << b);
                else if (op[2]) nv = m_sh | (8'h01 << b);
                else            nv = m_sh ^ (8'h01 << b);
            end
        end
        if (!mode) begin
            m_ac = chg ? nv : m_sh;
            m_pend = 0;
        end else begin
            if (sync && m_pend) begin m_ac = m_sh; m_pend = 0; end
            if (chg) m_pend = 1;
        end
        if (chg) m_sh = nv;
`ifdef SFR_LOCK_EN
        if (acc) m_phase = 0;
        else if (op[4]) begin
            if (m_phase == 0 && d == 8'hAA) begin m_phase = 1; m_last = m_cyc; end
            else if (m_phase == 1) begin
                if (d == 8'h55) begin m_phase = 2; m_last = m_cyc; end
                else m_phase = 0;
            end
        end
`endif
        m_cyc++;
    endtask

    task automatic step(input logic [4:0] op, input logic [7:0] d,
                        input int b, input bit mode, input bit sync);
        bus.i_op = op; bus.i_data = d; bus.i_bit = 4'(b);
        bus.i_sync_mode = mode; bus.i_sync = sync;
        @(posedge clk);
        model_step(op, d, b, mode, sync);
        #1;
        bus.i_op = '0; bus.i_sync = 1'b0;
    endtask

    task automatic mod_op(input logic [4:0] op, input logic [7:0] d,
                          input int b, input bit mode, input bit sync);
`ifdef SFR_LOCK_EN
        step(OP_SFR_KEY, SFR_KEY1, 0, mode, 1'b0);
        step(OP_SFR_KEY, SFR_KEY2, 0, mode, 1'b0);
`endif
        step(op, d, b, mode, sync);
    endtask

    task automatic do_reset(input logic [4:0] op, input bit sync);
        rst = 1'b1; bus.i_op = op; bus.i_data = 8'h5A;
        bus.i_bit = '0; bus.i_sync = sync;
        @(posedge clk);
        #1;
        rst = 1'b0; bus.i_op = '0; bus.i_sync = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic lk;
`ifdef SFR_LOCK_EN
        lk = 1'b1;
`else
        lk = 1'b0;
`endif
        bus.i_sync_mode = 1'b0;
        do_reset('0, 1'b0);
        n_run++;
        if (bus.o_active !== 8'h0F || bus.o_shadow !== 8'h0F ||
            bus.o_pending !== 1'b0 || bus.o_locked !== lk) begin
            n_fail++;
            $display("FAIL reset: act=%h sh=%h pend=%b lk=%b want 0f 0f 0 %b",
                     bus.o_active, bus.o_shadow, bus.o_pending, bus.o_locked, lk);
        end
    endtask

    task automatic test_write_mode0();
        mod_op(OP_SFR_WR, 8'h3C, 0, 1'b0, 1'b0);
        n_run++;
        if (bus.o_active !== 8'h3C || bus.o_shadow !== 8'h3C || bus.o_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_mode0: act=%h sh=%h pend=%b want 3c 3c 0",
                     bus.o_active, bus.o_shadow, bus.o_pending);
        end
    endtask

    task automatic test_sync();
        do_reset('0, 1'b0);
        mod_op(OP_SFR_SET, 8'h00, 7, 1'b1, 1'b0);
        n_run++;
        if (bus.o_active !== 8'h0F || bus.o_shadow !== 8'h8F || bus.o_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL set_pend: act=%h sh=%h pend=%b want 0f 8f 1",
                     bus.o_active, bus.o_shadow, bus.o_pending);
        end
        step('0, 8'h00, 0, 1'b1, 1'b1);
        n_run++;
        if (bus.o_active !== 8'h8F || bus.o_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_xfer: act=%h pend=%b want 8f 0", bus.o_active, bus.o_pending);
        end
        step('0, 8'h00, 0, 1'b1, 1'b1);
        n_run++;
        if (bus.o_active !== 8'h8F || bus.o_shadow !== 8'h8F || bus.o_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_idle: act=%h sh=%h pend=%b want 8f 8f 0",
                     bus.o_active, bus.o_shadow, bus.o_pending);
        end
    endtask

    task automatic test_tgl_with_sync();
        do_reset('0, 1'b0);
        mod_op(OP_SFR_SET, 8'h00, 7, 1'b1, 1'b0);
        mod_op(OP_SFR_TGL, 8'h00, 0, 1'b1, 1'b1);
        n_run++;
        if (bus.o_active !== 8'h8F || bus.o_shadow !== 8'h8E || bus.o_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL tgl_sync: act=%h sh=%h pend=%b want 8f 8e 1",
                     bus.o_active, bus.o_shadow, bus.o_pending);
        end
    endtask

    task automatic test_priority();
        do_reset('0, 1'b0);
        bus.i_sync_mode = 1'b0;
        mod_op(OP_SFR_WR | OP_SFR_CLR, 8'hFF, 0, 1'b0, 1'b0);
        n_run++;
        if (bus.o_shadow !== 8'hFF || bus.o_active !== 8'hFF) begin
            n_fail++;
            $display("FAIL wr_over_clr: sh=%h act=%h want ff ff", bus.o_shadow, bus.o_active);
        end
        mod_op(OP_SFR_CLR, 8'h00, 9, 1'b0, 1'b0);
        n_run++;
        if (bus.o_shadow !== 8'hFF || bus.o_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_oob: sh=%h pend=%b want ff 0", bus.o_shadow, bus.o_pending);
        end
        mod_op(OP_SFR_CLR | OP_SFR_SET, 8'h00, 2, 1'b0, 1'b0);
        n_run++;
        if (bus.o_shadow !== 8'hFB) begin
            n_fail++;
            $display("FAIL clr_over_set: sh=%h want fb", bus.o_shadow);
        end
        mod_op(OP_SFR_SET | OP_SFR_TGL, 8'h00, 2, 1'b0, 1'b0);
        n_run++;
        if (bus.o_shadow !== 8'hFF) begin
            n_fail++;
            $display("FAIL set_over_tgl: sh=%h want ff", bus.o_shadow);
        end
    endtask

    task automatic test_mode_flush();
        do_reset('0, 1'b0);
        mod_op(OP_SFR_SET, 8'h00, 5, 1'b1, 1'b0);
        n_run++;
        if (bus.o_shadow !== 8'h2F || bus.o_active !== 8'h0F || bus.o_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre: sh=%h act=%h pend=%b want 2f 0f 1",
                     bus.o_shadow, bus.o_active, bus.o_pending);
        end
        step('0, 8'h00, 0, 1'b0, 1'b0);
        n_run++;
        if (bus.o_active !== 8'h2F || bus.o_shadow !== 8'h2F || bus.o_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: act=%h sh=%h pend=%b want 2f 2f 0",
                     bus.o_active, bus.o_shadow, bus.o_pending);
        end
    endtask

`ifdef SFR_LOCK_EN
    task automatic test_lock();
        do_reset('0, 1'b0);
        step(OP_SFR_WR, 8'h55, 0, 1'b0, 1'b0);
        n_run++;
        if (bus.o_shadow !== 8'h0F || bus.o_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_locked: sh=%h lk=%b want 0f 1", bus.o_shadow, bus.o_locked);
        end
        step(OP_SFR_KEY, 8'hAA, 0, 1'b0, 1'b0);
        repeat (3) step('0, 8'h00, 0, 1'b0, 1'b0);
        step(OP_SFR_KEY, 8'h55, 0, 1'b0, 1'b0);
        n_run++;
        if (bus.o_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL unlock: lk=%b want 0", bus.o_locked);
        end
        step(OP_SFR_WR, 8'h12, 0, 1'b0, 1'b0);
        n_run++;
        if (bus.o_shadow !== 8'h12 || bus.o_active !== 8'h12 || bus.o_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_open: sh=%h act=%h lk=%b want 12 12 1",
                     bus.o_shadow, bus.o_active, bus.o_locked);
        end
        step(OP_SFR_KEY, 8'hAA, 0, 1'b0, 1'b0);
        repeat (5) step('0, 8'h00, 0, 1'b0, 1'b0);
        step(OP_SFR_KEY, 8'h55, 0, 1'b0, 1'b0);
        n_run++;
        if (bus.o_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL key_expired: lk=%b want 1", bus.o_locked);
        end
        step(OP_SFR_KEY, 8'hAA, 0, 1'b0, 1'b0);
        step(OP_SFR_KEY, 8'h33, 0, 1'b0, 1'b0);
        step(OP_SFR_KEY, 8'h55, 0, 1'b0, 1'b0);
        n_run++;
        if (bus.o_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL key_wrong: lk=%b want 1", bus.o_locked);
        end
        step(OP_SFR_KEY, 8'hAA, 0, 1'b0, 1'b0);
        step(OP_SFR_KEY, 8'h55, 0, 1'b0, 1'b0);
        repeat (4) step('0, 8'h00, 0, 1'b0, 1'b0);
        n_run++;
        if (bus.o_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL open_hold: lk=%b want 0", bus.o_locked);
        end
        step('0, 8'h00, 0, 1'b0, 1'b0);
        n_run++;
        if (bus.o_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL open_expire: lk=%b want 1", bus.o_locked);
        end
    endtask
`else
    task automatic test_key_ignored();
        logic [7:0] exp_sh;
        exp_sh = m_sh;
        step(OP_SFR_KEY, 8'hAA, 0, 1'b0, 1'b0);
        step(OP_SFR_KEY, 8'h55, 0, 1'b0, 1'b0);
        n_run++;
        if (bus.o_shadow !== exp_sh || bus.o_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL key_ignored: sh=%h lk=%b want %h 0",
                     bus.o_shadow, bus.o_locked, exp_sh);
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic lk;
        do_reset('0, 1'b0);
        mod_op(OP_SFR_SET, 8'h00, 6, 1'b1, 1'b0);
`ifdef SFR_LOCK_EN
        lk = 1'b1;
        step(OP_SFR_KEY, 8'hAA, 0, 1'b1, 1'b0);
`else
        lk = 1'b0;
`endif
        do_reset(OP_SFR_WR, 1'b1);
        n_run++;
        if (bus.o_active !== 8'h0F || bus.o_shadow !== 8'h0F ||
            bus.o_pending !== 1'b0 || bus.o_locked !== lk) begin
            n_fail++;
            $display("FAIL reset_mid: act=%h sh=%h pend=%b lk=%b want 0f 0f 0 %b",
                     bus.o_active, bus.o_shadow, bus.o_pending, bus.o_locked, lk);
        end
        step(OP_SFR_KEY, 8'h55, 0, 1'b1, 1'b0);
        n_run++;
        if (bus.o_locked !== lk) begin
            n_fail++;
            $display("FAIL reset_key1: lk=%b want %b", bus.o_locked, lk);
        end
    endtask

    task automatic test_random();
        logic [4:0] op;
        logic [7:0] d;
        bit         mode, sync;
        int         b, shown;
        shown = 0;
        mode  = 1'b0;
        do_reset('0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    op = '0;
                2:       op = OP_SFR_WR;
                3:       op = OP_SFR_CLR;
                4:       op = OP_SFR_SET;
                5:       op = OP_SFR_TGL;
                6:       op = 5'($urandom_range(0, 31));
                default: op = OP_SFR_KEY;
            endcase
            case ($urandom_range(0, 2))
                0:       d = 8'hAA;
                1:       d = 8'h55;
                default: d = 8'($urandom_range(0, 255));
            endcase
            b = $urandom_range(0, 11);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sync = ($urandom_range(0, 3) == 0);
            step(op, d, b, mode, sync);
            n_run++;
            if (bus.o_active !== m_ac || bus.o_shadow !== m_sh ||
                bus.o_pending !== m_pend || bus.o_locked !== m_locked()) begin
                n_fail++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random[%0d]: act=%h sh=%h pend=%b lk=%b want %h %h %b %b",
                             i, bus.o_active, bus.o_shadow, bus.o_pending, bus.o_locked,
                             m_ac, m_sh, m_pend, m_locked());
                end
            end
        end
    endtask

    initial begin
        bus.i_op = '0; bus.i_data = '0; bus.i_bit = '0;
        bus.i_sync_mode = 1'b0; bus.i_sync = 1'b0;
        model_reset();
        test_reset();
        test_write_mode0();
        test_sync();
        test_tgl_with_sync();
        test_priority();
        test_mode_flush();
`ifdef SFR_LOCK_EN
        test_lock();
`else
        test_key_ignored();
`endif
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
